gpio_in_filter: RTL

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/gpio_in_filter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: conditions raw GPIO pad levels for the GPIO data register.
// Each pin passes through a two-flop synchronizer and a counter-based debounce
// filter; the filter can be bypassed at run time with filt_en_i.
// Optional edge detection and sticky interrupt pending flags are built only when
// the macro GPIO_IN_IRQ_EN is defined; otherwise edge_o, irq_pend_o and irq_o
// are constant 0 and edge_sel_i / irq_clr_i are ignored.

module gpio_in_filter #(
    parameter int NPIN      = 2,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [NPIN-1:0]     pin_i,
    input  logic                filt_en_i,
    input  logic [2*NPIN-1:0]   edge_sel_i,
    input  logic [NPIN-1:0]     irq_clr_i,
    output logic [NPIN-1:0]     pin_o,
    output logic [NPIN-1:0]     edge_o,
    output logic [NPIN-1:0]     irq_pend_o,
    output logic                irq_o
);

    // Terminal count: a mismatch seen while the counter sits here is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NPIN-1:0]  sync1_r;
    logic [NPIN-1:0]  sync2_r;
    logic [NPIN-1:0]  stb_r;
    logic [NPIN-1:0]  stb_nxt_s;
    logic [CNT_W-1:0] cnt_r     [NPIN];
    logic [CNT_W-1:0] cnt_nxt_s [NPIN];

    // Two-flop synchronizer bringing the asynchronous pad levels into hclk.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sync1_r <= {NPIN{1'b0}};
            sync2_r <= {NPIN{1'b0}};
        end else begin
            sync1_r <= pin_i;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next state: any return to the stable level restarts the count,
    // and the counter saturates at CNT_MAX because it loads stb there instead.
    always_comb begin
        stb_nxt_s = stb_r;
        for (int k = 0; k < NPIN; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
            if (!filt_en_i) begin
                stb_nxt_s[k] = sync2_r[k];
                cnt_nxt_s[k] = CNT_ZERO;
            end else if (sync2_r[k] == stb_r[k]) begin
                cnt_nxt_s[k] = CNT_ZERO;
            end else if (cnt_r[k] == CNT_MAX) begin
                stb_nxt_s[k] = sync2_r[k];
                cnt_nxt_s[k] = CNT_ZERO;
            end else begin
                cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
            end
        end
    end

    // Debounce state registers: stable level and per-pin counter.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            stb_r <= {NPIN{1'b0}};
            for (int k = 0; k < NPIN; k++) begin
                cnt_r[k] <= CNT_ZERO;
            end
        end else begin
            stb_r <= stb_nxt_s;
            for (int k = 0; k < NPIN; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    assign pin_o = stb_r;

`ifdef GPIO_IN_IRQ_EN

    // True when an edge whose new level is new_lvl is enabled by sel
    // (sel[0] = rising, sel[1] = falling).
    function automatic logic edge_match(input logic new_lvl, input logic [1:0] sel);
        return (new_lvl & sel[0]) | (~new_lvl & sel[1]);
    endfunction

    logic [NPIN-1:0] stb_d_r;
    logic [NPIN-1:0] edge_r;
    logic [NPIN-1:0] pend_r;
    logic [NPIN-1:0] pend_nxt_s;

    // Edge pulse: registered compare of the stable level against its previous
    // value; stb_d_r holds the new level while edge_r is high.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            stb_d_r <= {NPIN{1'b0}};
            edge_r  <= {NPIN{1'b0}};
        end else begin
            stb_d_r <= stb_r;
            edge_r  <= stb_r ^ stb_d_r;
        end
    end

    // Pending next state: a matching edge wins over a simultaneous clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int k = 0; k < NPIN; k++) begin
            if (edge_r[k] && edge_match(stb_d_r[k], edge_sel_i[2*k +: 2])) begin
                pend_nxt_s[k] = 1'b1;
            end else if (irq_clr_i[k]) begin
                pend_nxt_s[k] = 1'b0;
            end else begin
                pend_nxt_s[k] = pend_r[k];
            end
        end
    end

    // Sticky pending flags.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            pend_r <= {NPIN{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign edge_o     = edge_r;
    assign irq_pend_o = pend_r;
    assign irq_o      = |pend_r;

`else

    // Interrupt inputs have no function in this build.
    logic unused_irq_s;
    assign unused_irq_s = ^{edge_sel_i, irq_clr_i};

    assign edge_o     = {NPIN{1'b0}};
    assign irq_pend_o = {NPIN{1'b0}};
    assign irq_o      = 1'b0;

`endif

endmodule
